instr_encode_loader: RTL and testbench

Packs instruction fields into 32-bit Mini RISC instruction words and writes them sequentially into instruction memory through a single write port. It is the encoder counterpart of the instruction decoder and sits between the test/boot front end and instruction memory. It loads a program of up to DEPTH words, then signals completion.

---
 rtl/mini_risc_pkg.sv | 35 +++
 rtl/instr_encode_loader_if.sv | 28 ++
 rtl/instr_field_packer.sv | 41 ++++
 rtl/instr_encode_loader.sv | 107 ++++++++++
 tb/tb_instr_encode_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mini_risc_pkg.sv
// Mini RISC shared definitions: instruction field positions, format codes,
// loader states and the NOP word.
package mini_risc_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 3;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM16_MSB  = 15;
    localparam int IMM16_LSB  = 0;
    localparam int IMM26_MSB  = 25;
    localparam int IMM26_LSB  = 0;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_ILL = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } load_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Field-bundle handshake plus instruction-memory write port of the loader.
interface instr_encode_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [3:0]        funct;
    logic [15:0]       imm16;
    logic [25:0]       imm26;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, fmt, opcode, rs, rt, rd, funct, imm16, imm26,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, fmt, opcode, rs, rt, rd, funct, imm16, imm26,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational packer: maps an instruction format and its fields onto a
// 32-bit Mini RISC word. The illegal format packs to the NOP word.
module instr_field_packer
    import mini_risc_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [3:0]  funct,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    output logic [31:0] word
);

    always_comb begin
        word = NOP_WORD;
        case (fmt)
            FMT_R: begin
                word[OPCODE_MSB:OPCODE_LSB] = opcode;
                word[RS_MSB:RS_LSB]         = rs;
                word[RT_MSB:RT_LSB]         = rt;
                word[RD_MSB:RD_LSB]         = rd;
                word[FUNCT_MSB:FUNCT_LSB]   = funct;
            end
            FMT_I: begin
                word[OPCODE_MSB:OPCODE_LSB] = opcode;
                word[RS_MSB:RS_LSB]         = rs;
                word[RT_MSB:RT_LSB]         = rt;
                word[IMM16_MSB:IMM16_LSB]   = imm16;
            end
            FMT_J: begin
                word[OPCODE_MSB:OPCODE_LSB] = opcode;
                word[IMM26_MSB:IMM26_LSB]   = imm26;
            end
            default: word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: packs field bundles and writes them to imem
// sequentially from address 0. Optional macro ENC_FMT_CHECK_EN drops illegal formats and flags err.
module instr_encode_loader
    import mini_risc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 finish,
    instr_encode_loader_if.slave bus,
    output logic [ADDR_W:0]      word_count,
    output logic                 done,
    output logic                 err
);

    localparam logic [1:0] IDLE = LD_IDLE;
    localparam logic [1:0] LOAD = LD_LOAD;
    localparam logic [1:0] DONE = LD_DONE;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [1:0]      state;
    logic [31:0]     packed_word;
    logic [ADDR_W:0] wc_next;
    logic            accept;
    logic            fmt_ill;
    logic            wr_en;

    instr_field_packer u_packer (
        .fmt    (bus.fmt),
        .opcode (bus.opcode),
        .rs     (bus.rs),
        .rt     (bus.rt),
        .rd     (bus.rd),
        .funct  (bus.funct),
        .imm16  (bus.imm16),
        .imm26  (bus.imm26),
        .word   (packed_word)
    );

    assign bus.in_ready = (state == LOAD) && (word_count < DEPTH_C);
    assign accept       = bus.in_valid && bus.in_ready;
    assign done         = (state == DONE);
    assign wc_next      = word_count + 1'b1;

`ifdef ENC_FMT_CHECK_EN
    assign fmt_ill = (bus.fmt == FMT_ILL);
`else
    assign fmt_ill = 1'b0;
`endif

    // An illegal bundle is still consumed (accept) but never reaches memory.
    assign wr_en = accept && !fmt_ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            word_count     <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        word_count <= '0;
                    end
                end
                LOAD: begin
                    if (wr_en) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= word_count[ADDR_W-1:0];
                        bus.imem_wdata <= packed_word;
                        word_count     <= wc_next;
                        if (wc_next == DEPTH_C) begin
                            state <= DONE;
                        end
                    end else if (!accept && finish) begin
                        // finish only wins in a cycle with no accept
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ENC_FMT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((state != LOAD) && start) begin
            err <= 1'b0;
        end else if (accept && fmt_ill) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: table-driven encodes, scoreboarded writes,
// and hand-written sequences for boundary, early finish, illegal format and reset.
module tb_instr_encode_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  funct;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            finish;
    logic [ADDR_W:0] word_count;
    logic            done;
    logic            err;

    int tests = 0;
    int fails = 0;

    wr_t               exp_q[$];
    logic [ADDR_W-1:0] exp_addr;
    vec_t              vecs[4];
    vec_t              ill;

    instr_encode_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .finish     (finish),
        .bus        (bus),
        .word_count (word_count),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("wr_data", bus.imem_wdata, e.word);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic drive(input vec_t v);
        bus.fmt    = v.fmt;
        bus.opcode = v.opcode;
        bus.rs     = v.rs;
        bus.rt     = v.rt;
        bus.rd     = v.rd;
        bus.funct  = v.funct;
        bus.imm16  = v.imm16;
        bus.imm26  = v.imm26;
        bus.in_valid = 1'b1;
    endtask

    // Present one bundle and return just after the edge that accepts it.
    task automatic send(input vec_t v, input bit exp_write);
        int waited;
        waited = 0;
        drive(v);
        while (bus.in_ready !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("send_accept_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            if (exp_write) begin
                exp_q.push_back('{addr: exp_addr, word: v.word});
                exp_addr++;
            end
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
        check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
        check({tag, "_word_count"}, 32'(word_count),     32'd0);
        check({tag, "_done"},       32'(done),           32'd0);
        check({tag, "_err"},        32'(err),            32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{fmt: 2'b00, opcode: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd3, funct: 4'd4,
                    imm16: 16'h0, imm26: 26'h0, word: 32'h0022_1804};
        vecs[1] = '{fmt: 2'b01, opcode: 6'h08, rs: 5'd5, rt: 5'd6, rd: 5'd0, funct: 4'd0,
                    imm16: 16'hBEEF, imm26: 26'h0, word: 32'h20A6_BEEF};
        vecs[2] = '{fmt: 2'b10, opcode: 6'h02, rs: 5'd0, rt: 5'd0, rd: 5'd0, funct: 4'd0,
                    imm16: 16'h0, imm26: 26'h100, word: 32'h0800_0100};
        vecs[3] = '{fmt: 2'b00, opcode: 6'h3F, rs: 5'h1F, rt: 5'h1F, rd: 5'h1F, funct: 4'hF,
                    imm16: 16'hFFFF, imm26: 26'h3FF_FFFF, word: 32'hFFFF_F80F};
        ill     = '{fmt: 2'b11, opcode: 6'h2A, rs: 5'd7, rt: 5'd9, rd: 5'd11, funct: 4'h5,
                    imm16: 16'h1234, imm26: 26'h155_5555, word: 32'h0000_0000};

        rst_n  = 1'b0;
        start  = 1'b0;
        finish = 1'b0;
        exp_addr = '0;
        bus.in_valid = 1'b0;
        drive(vecs[0]);
        bus.in_valid = 1'b0;

        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // in_valid in IDLE is ignored
        bus.in_valid = 1'b1;
        tick();
        tick();
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);
        check("idle_word_count", 32'(word_count), 32'd0);
        bus.in_valid = 1'b0;

        // Table: four encodes filling DEPTH exactly
        do_start();
        check("load_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            send(vecs[i], 1'b1);
            check($sformatf("table_wc_%0d", i), 32'(word_count), 32'(i + 1));
        end
        check("full_done_with_last_we", 32'(done), 32'd1);
        check("full_last_we", 32'(bus.imem_we), 32'd1);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        check("full_hold_addr", 32'(bus.imem_addr), 32'd3);
        check("full_hold_data", bus.imem_wdata, 32'hFFFF_F80F);

        // Boundary: five bundles streamed, the fifth is never taken
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            send(vecs[(i + 1) % DEPTH], 1'b1);
        end
        drive(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fifth_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
            tick();
        end
        check("fifth_word_count", 32'(word_count), 32'd4);
        check("fifth_done", 32'(done), 32'd1);
        bus.in_valid = 1'b0;

        // Early finish; finish together with an accept is not honoured
        do_start();
        send(vecs[1], 1'b1);
        finish = 1'b1;
        send(vecs[2], 1'b1);
        finish = 1'b0;
        bus.in_valid = 1'b0;
        check("finish_accept_not_done", 32'(done), 32'd0);
        check("finish_accept_in_ready", 32'(bus.in_ready), 32'd1);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("early_done", 32'(done), 32'd1);
        check("early_word_count", 32'(word_count), 32'd2);
        do_start();
        check("restart_word_count", 32'(word_count), 32'd0);
        send(vecs[2], 1'b1);
        bus.in_valid = 1'b0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("restart_done", 32'(done), 32'd1);

        // Illegal format between two legal words
        do_start();
        send(vecs[0], 1'b1);
`ifdef ENC_FMT_CHECK_EN
        send(ill, 1'b0);
`else
        send(ill, 1'b1);
`endif
        send(vecs[1], 1'b1);
        bus.in_valid = 1'b0;
        tick();
`ifdef ENC_FMT_CHECK_EN
        check("ill_err", 32'(err), 32'd1);
        check("ill_word_count", 32'(word_count), 32'd2);
`else
        check("ill_err", 32'(err), 32'd0);
        check("ill_word_count", 32'(word_count), 32'd3);
`endif
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("ill_done", 32'(done), 32'd1);
        do_start();
        check("ill_err_cleared", 32'(err), 32'd0);

        // Async reset mid-load after three writes
        send(vecs[0], 1'b1);
        send(vecs[1], 1'b1);
        send(vecs[2], 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        check("pre_reset_word_count", 32'(word_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("post_reset_done", 32'(done), 32'd0);
        do_start();
        check("post_reset_start_ready", 32'(bus.in_ready), 32'd1);
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
